rpi_bus_if: RTL and testbench
=============================

// Module: rpi_bus_if
// PURPOSE
//  Front end for the RPi 8-bit parallel bus. Synchronises bus_clk/bus_rnw/bus_data
//  into clk_100mhz and detects bus_clk rising edges. Write bytes go into an RX FIFO
//  that feeds a valid/ready byte stream to downstream logic (test/hash cores).
//  Read bytes come from a single-entry TX holding register and are driven onto bus_data.
// PARAMETERS
//  DEPTH  16  RX FIFO depth in bytes; power of 2, >= 2
//  AW     4   $clog2(DEPTH); RX pointer width
// PORTS
//  clk_100mhz  in     1     system clock
//  reset       in     1     synchronous, active-high reset
//  bus_clk     in     1     RPi strobe; one transfer per rising edge (async)
//  bus_data    inout  8     RPi data; driven by block only while bus_rnw==1
//  bus_rnw     in     1     1 = RPi reads, 0 = RPi writes (async)
//  rx_data     out    8     FIFO head byte (first-word-fall-through)
//  rx_valid    out    1     FIFO not empty
//  rx_ready    in     1     consumer accepts rx_data when rx_valid & rx_ready
//  rx_count    out    AW+1  bytes currently in FIFO, 0..DEPTH
//  tx_data     in     8     byte to return to RPi
//  tx_valid    in     1     tx_data offered
//  tx_ready    out    1     TX holding register empty
//  overflow    out    1     sticky: a write byte was dropped (FIFO full)
//  underrun    out    1     sticky: RPi read while TX register empty
// BEHAVIOUR
//  Reset: rx_valid=0, rx_count=0, tx_ready=1, overflow=0, underrun=0, TX reg=8'h00,
//   pointers=0. bus_clk sync chain (s1,s2,s3) resets to 1; rnw/data chains reset to 0.
//   A bus_clk held high across reset produces no strobe. Reset mid-transfer flushes FIFO/TX.
//  Sync: 2-FF on bus_clk, bus_rnw, bus_data; s3 = delayed s2. strobe = s2 & ~s3,
//   1-cycle pulse, 3 clk_100mhz after bus_clk rise. Sample rnw_s2/data_s2 on strobe.
//  Write (strobe & rnw_s2==0): push data_s2. Push succeeds if count<DEPTH, or if
//   count==DEPTH and a pop occurs in the same cycle. Otherwise drop byte, set overflow.
//  Pop: rx_valid & rx_ready; rd_ptr+1. Push+pop same cycle: count unchanged.
//  Pointers wrap modulo DEPTH. rx_count updates the cycle after a push/pop.
//  TX load: tx_valid & tx_ready -> TX reg <= tx_data, tx_ready <= 0 next cycle.
//  Read (strobe & rnw_s2==1): if TX full, mark empty (tx_ready=1 next cycle). Else
//   set underrun. TX reg is not loaded on the same cycle it is consumed.
//  Pin drive: bus_data = bus_rnw (raw pin) ? bus_out : 8'bz, where bus_out =
//   TX reg when full, else 8'h00. Raw pin gives the RPi data before its strobe.
//  overflow/underrun clear only on reset.
// TESTING
//  1 Write 0..255, rx_ready=1 -> rx stream 0..255 in order, overflow=0, rx_count ends 0.
//  2 rx_ready=0, write 20 bytes 0x00..0x13 -> rx_count=16, overflow=1; drain -> 0x00..0x0F.
//  3 FIFO full, rx_ready=1, write 0x55 -> byte accepted, rx_count stays 16, overflow=0.
//  4 tx_data=0xA5, tx_valid pulse; RPi read -> bus_data=0xA5 while rnw=1; tx_ready=1 after strobe.
//  5 RPi read with TX empty -> bus_data=0x00, underrun=1; bus_data=Z whenever bus_rnw=0.
//  6 Assert reset with bus_clk high and 5 bytes queued -> no strobe; rx_valid=0, count=0.

Source files
------------

// File: rtl/rpi_bus_if.sv
// rpi_bus_if
//   Front end for the RPi 8-bit parallel bus. bus_clk, bus_rnw and bus_data are
//   brought into the clk_100mhz domain through 2-FF synchronisers. A rising edge
//   of the synchronised bus_clk is a strobe: one bus transfer.
//   RPi writes are pushed into an RX FIFO that presents a first-word-fall-through
//   byte stream downstream. RPi reads take the byte from a single-entry TX holding
//   register, which is driven onto bus_data.
//
// Ports
//   clk_100mhz  in     system clock
//   reset       in     synchronous, active-high reset
//   bus_clk     in     RPi strobe, asynchronous; one transfer per rising edge
//   bus_data    inout  RPi data; driven by this block only while bus_rnw==1
//   bus_rnw     in     1 = RPi reads, 0 = RPi writes (asynchronous)
//   rx_data     out    FIFO head byte
//   rx_valid    out    FIFO not empty
//   rx_ready    in     consumer accepts rx_data
//   rx_count    out    bytes held in the FIFO, 0..DEPTH
//   tx_data     in     byte to return to the RPi
//   tx_valid    in     tx_data offered
//   tx_ready    out    TX holding register empty
//   overflow    out    sticky: a write byte was dropped because the FIFO was full
//   underrun    out    sticky: the RPi read while the TX register was empty
//
// Handshakes: a byte moves on every clk_100mhz edge where valid and ready are
// both high; valid never depends on ready, and the data is stable while valid is
// high and ready is low (rx_* stream and tx_* load alike).

module rpi_bus_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_100mhz,
    input  logic          reset,
    input  logic          bus_clk,
    inout  wire  [7:0]    bus_data,
    input  logic          bus_rnw,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [AW:0]   rx_count,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          overflow,
    output logic          underrun
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    // Synchronisers. The bus_clk chain resets to 1 so a bus_clk that is already
    // high when reset releases is not mistaken for a new rising edge.
    logic       clk_s1, clk_s2, clk_s3;
    logic       rnw_s1, rnw_s2;
    logic [7:0] data_s1, data_s2;
    logic       strobe;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            rnw_s1  <= 1'b0;
            rnw_s2  <= 1'b0;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            clk_s1  <= bus_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            rnw_s1  <= bus_rnw;
            rnw_s2  <= rnw_s1;
            data_s1 <= bus_data;
            data_s2 <= data_s1;
        end
    end

    // rnw and data travel through chains of the same length as bus_clk, so they
    // are settled in the _s2 stage when the strobe fires.
    assign strobe = clk_s2 & ~clk_s3;

    // RX FIFO
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        push_req, push_ok, pop;

    assign push_req = strobe & ~rnw_s2;
    assign pop      = rx_valid & rx_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok  = push_req & ((count < FULL_COUNT) | pop);

    always_ff @(posedge clk_100mhz) begin
        if (push_ok) mem[wr_ptr] <= data_s2;
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

    assign rx_data  = mem[rd_ptr];
    assign rx_valid = (count != '0);
    assign rx_count = count;

    // TX holding register. Load needs it empty and a read consumes it only when
    // full, so load and consume can never land on the same cycle.
    logic [7:0] tx_reg;
    logic       tx_full;
    logic       tx_load, rd_strobe;
    logic [7:0] bus_out;

    assign tx_load   = tx_valid & ~tx_full;
    assign rd_strobe = strobe & rnw_s2;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            tx_reg   <= 8'h00;
            tx_full  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_reg  <= tx_data;
                tx_full <= 1'b1;
            end
            if (rd_strobe) begin
                if (tx_full) tx_full  <= 1'b0;
                else         underrun <= 1'b1;
            end
        end
    end

    assign tx_ready = ~tx_full;
    assign bus_out  = tx_full ? tx_reg : 8'h00;

    // The raw pin gates the driver so data is on the bus before the RPi strobes.
    assign bus_data = bus_rnw ? bus_out : 8'hzz;

endmodule

// File: tb/tb_rpi_bus_if.sv
module tb_rpi_bus_if;

  // clock / reset
  logic clk_100mhz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  logic       bus_clk  = 1'b0;
  logic       bus_rnw  = 1'b0;
  logic       tb_en    = 1'b1;
  logic [7:0] tb_data  = 8'h00;
  wire  [7:0] bus_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] rx_count;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       overflow;
  logic       underrun;

  assign bus_data = tb_en ? tb_data : 8'hzz;

  rpi_bus_if #(.DEPTH(16), .AW(4)) dut (
    .clk_100mhz(clk_100mhz),
    .reset(reset),
    .bus_clk(bus_clk),
    .bus_data(bus_data),
    .bus_rnw(bus_rnw),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_count(rx_count),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .overflow(overflow),
    .underrun(underrun)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_byte;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard: every accepted rx byte is compared against the expected queue,
  // sampled just before the edge on which the handshake completes
  always @(negedge clk_100mhz) begin
    #3;
    if (!reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk_100mhz); reset = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    reset = 1'b0;
    repeat (2) @(negedge clk_100mhz);
  endtask

  // strobe lands 2 edges after bus_clk rises, the push on the 3rd;
  // pop_at_push raises rx_ready for exactly that 3rd edge
  task automatic rpi_write(input logic [7:0] b, input bit pop_at_push);
    @(negedge clk_100mhz);
    bus_rnw = 1'b0; tb_en = 1'b1; tb_data = b;
    @(negedge clk_100mhz); bus_clk = 1'b1;
    if (pop_at_push) begin
      repeat (2) @(negedge clk_100mhz); rx_ready = 1'b1;
      @(negedge clk_100mhz); rx_ready = 1'b0;
      @(negedge clk_100mhz);
    end else begin
      repeat (4) @(negedge clk_100mhz);
    end
    bus_clk = 1'b0;
    repeat (4) @(negedge clk_100mhz);
  endtask

  task automatic rpi_read(output logic [7:0] b);
    @(negedge clk_100mhz);
    tb_en = 1'b0; bus_rnw = 1'b1;
    @(negedge clk_100mhz); b = bus_data;
    bus_clk = 1'b1;
    repeat (4) @(negedge clk_100mhz); bus_clk = 1'b0;
    repeat (4) @(negedge clk_100mhz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_count", {27'h0, rx_count}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_underrun", {31'h0, underrun}, 32'h0);

    // 1: streaming 0..255 with the consumer always ready
    rx_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i));
      rpi_write(8'(i), 1'b0);
    end
    repeat (4) @(negedge clk_100mhz);
    rx_ready = 1'b0;
    check("t1_left", exp_q.size(), 32'h0);
    check("t1_count", {27'h0, rx_count}, 32'h0);
    check("t1_overflow", {31'h0, overflow}, 32'h0);

    // 2: overfill with the consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      rpi_write(8'(i), 1'b0);
    end
    check("t2_count_full", {27'h0, rx_count}, 32'd16);
    check("t2_overflow", {31'h0, overflow}, 32'h1);
    check("t2_valid", {31'h0, rx_valid}, 32'h1);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk_100mhz);
    rx_ready = 1'b0;
    check("t2_left", exp_q.size(), 32'h0);
    check("t2_count_empty", {27'h0, rx_count}, 32'h0);

    // 3: write into a full FIFO on the same cycle as a pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      rpi_write(8'(i), 1'b0);
    end
    exp_q.push_back(8'h55);
    rpi_write(8'h55, 1'b1);
    check("t3_count", {27'h0, rx_count}, 32'd16);
    check("t3_overflow", {31'h0, overflow}, 32'h0);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk_100mhz);
    rx_ready = 1'b0;
    check("t3_left", exp_q.size(), 32'h0);

    // 4: TX load then RPi read
    do_reset();
    @(negedge clk_100mhz); tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk_100mhz); tx_valid = 1'b0;
    check("t4_tx_ready_busy", {31'h0, tx_ready}, 32'h0);
    rpi_read(rd_byte);
    check("t4_bus_data", {24'h0, rd_byte}, 32'hA5);
    check("t4_tx_ready_free", {31'h0, tx_ready}, 32'h1);
    check("t4_underrun", {31'h0, underrun}, 32'h0);
    check("t4_bus_idle", {24'h0, bus_data}, 32'h0);

    // 5: read with TX empty, and no drive while the RPi writes
    rpi_read(rd_byte);
    check("t5_bus_data", {24'h0, rd_byte}, 32'h0);
    check("t5_underrun", {31'h0, underrun}, 32'h1);
    @(negedge clk_100mhz); tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk_100mhz); tx_valid = 1'b0;
    bus_rnw = 1'b0; tb_en = 1'b1; tb_data = 8'h3C;
    @(negedge clk_100mhz);
    check("t5_no_drive", {24'h0, bus_data}, 32'h3C);

    // 6: reset with bus_clk held high and bytes queued
    do_reset();
    for (int i = 0; i < 5; i++) rpi_write(8'(8'h10 + i), 1'b0);
    check("t6_count_pre", {27'h0, rx_count}, 32'd5);
    @(negedge clk_100mhz); reset = 1'b1; tb_data = 8'h77;
    @(negedge clk_100mhz); bus_clk = 1'b1;
    repeat (3) @(negedge clk_100mhz); reset = 1'b0;
    repeat (8) @(negedge clk_100mhz);
    check("t6_valid", {31'h0, rx_valid}, 32'h0);
    check("t6_count", {27'h0, rx_count}, 32'h0);
    bus_clk = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    rpi_write(8'h99, 1'b0);
    check("t6_count_after", {27'h0, rx_count}, 32'd1);
    check("t6_head", {24'h0, rx_data}, 32'h99);
    check("t6_overflow", {31'h0, overflow}, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
